// File: rtl/partial_sum_accumulator.sv
// Partial-sum accumulator: adds NUM_TERMS signed beats into one saturated
// signed word and presents it on a valid/ready output port that feeds the
// downstream holding register.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; no beats accepted, no result presented
//   ACCUM | accepting beats, clamping the running sum after each beat
//   DONE  | final sum held on out_data until the downstream register loads
module partial_sum_accumulator #(
  parameter int DATA_W    = 6,
  parameter int NUM_TERMS = 4,
  parameter int CNT_W     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     sat_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(NUM_TERMS - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic signed [DATA_W-1:0]   acc;
  logic [CNT_W-1:0]           count;
  logic                       accept;
  logic                       xfer;
  logic                       last_beat;
  logic signed [DATA_W:0]     sum_wide;
  logic signed [DATA_W-1:0]   sum_sat;
  logic                       clamp;

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign last_beat = (count == LAST_CNT);

  // One guard bit is enough: the two operands are DATA_W wide, so the sum
  // overflowed exactly when the guard bit disagrees with the sign bit.
  always_comb begin
    sum_wide = {acc[DATA_W-1], acc} + {in_data[DATA_W-1], in_data};
    clamp    = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];
    if (!clamp)
      sum_sat = sum_wide[DATA_W-1:0];
    else if (sum_wide[DATA_W])
      sum_sat = SAT_MIN;
    else
      sum_sat = SAT_MAX;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)              state_nxt = ACCUM;
      ACCUM:   if (accept && last_beat) state_nxt = DONE;
      DONE:    if (xfer)               state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs are pure functions of the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Running sum, beat count and sticky clamp flag. acc is frozen in DONE,
  // so it can drive out_data directly and stays stable while out_valid=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
    end else if (state == IDLE && start) begin
      acc      <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      acc   <= sum_sat;
      count <= count + CNT_W'(1);
      if (clamp)
        sat_flag <= 1'b1;
    end
  end

  assign out_data = acc;

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Bench for partial_sum_accumulator: directed scenarios with literal
// expected sums plus randomized operations, all checked every cycle
// against an operation-level model kept in the bench.
module tb_partial_sum_accumulator;

  localparam int DATA_W    = 6;
  localparam int NUM_TERMS = 4;
  localparam int VMAX      = 31;
  localparam int VMIN      = -32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              sat_flag;

  int checks = 0;
  int failures = 0;

  int xfer_data[$];
  int xfer_sat[$];

  partial_sum_accumulator #(.DATA_W(DATA_W), .NUM_TERMS(NUM_TERMS), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Operation-level model: phase 0 = no operation, 1 = collecting beats,
  // 2 = result pending. Inputs are stable at the falling edge, so the
  // model reads them there and advances to what the next rising edge does.
  initial begin
    int ph = 0, sum = 0, nbeats = 0, sat = 0, s;
    bit live = 0, just_reset = 0;
    forever begin
      @(negedge clk);
      if (live) begin
        chk("busy", int'(busy), int'(ph != 0));
        chk("in_ready", int'(in_ready), int'(ph == 1));
        chk("out_valid", int'(out_valid), int'(ph == 2));
        if (ph == 2 || just_reset) begin
          chk("out_data", int'($signed(out_data)), sum);
          chk("sat_flag", int'(sat_flag), sat);
        end
      end
      if (out_valid && out_ready && !reset) begin
        xfer_data.push_back(int'($signed(out_data)));
        xfer_sat.push_back(int'(sat_flag));
      end
      just_reset = 0;
      if (reset) begin
        live = 1; just_reset = 1;
        ph = 0; sum = 0; nbeats = 0; sat = 0;
      end else begin
        case (ph)
          0: if (start) begin ph = 1; sum = 0; nbeats = 0; sat = 0; end
          1: if (in_valid) begin
               s = sum + int'($signed(in_data));
               if (s > VMAX) begin s = VMAX; sat = 1; end
               if (s < VMIN) begin s = VMIN; sat = 1; end
               sum = s;
               nbeats++;
               if (nbeats == NUM_TERMS) ph = 2;
             end
          default: if (out_ready) ph = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit noise_valid, input int noise_data);
    start    = 1'b1;
    in_valid = noise_valid;
    in_data  = DATA_W'(noise_data);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_beat(input int d, input int gap, input bit rnd_start);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom_range(63));
      start    = rnd_start ? 1'($urandom_range(1)) : 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    start    = rnd_start ? 1'($urandom_range(1)) : 1'b0;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_out(input int hold, input bit pulse_start);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout: got 0 expected 1 at %0t", $time);
    end
    for (int h = 0; h < hold; h++) begin
      start = pulse_start ? 1'($urandom_range(1)) | (h == 0) : 1'b0;
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_last(input string name, input int exp_data, input int exp_sat);
    int sz;
    sz = xfer_data.size();
    chk({name, "_xfer"}, int'(sz > 0), 1);
    if (sz > 0) begin
      chk({name, "_data"}, xfer_data[sz-1], exp_data);
      chk({name, "_sat"}, xfer_sat[sz-1], exp_sat);
    end
  endtask

  task automatic run_op(input int b[4], input int gap, input int hold, input bit pulse);
    start_op(1'b0, 0);
    for (int i = 0; i < 4; i++) send_beat(b[i], gap, pulse);
    wait_out(hold, pulse);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_valid", int'(out_valid), 0);

    // 1: plain sum, result visible the cycle after the last beat.
    start_op(1'b0, 0);
    send_beat(5, 0, 0); send_beat(7, 0, 0); send_beat(-3, 0, 0);
    chk("t1_busy_before_last", int'(out_valid), 0);
    send_beat(10, 0, 0);
    chk("t1_latency", int'(out_valid), 1);
    wait_out(0, 0);
    check_last("t1", 19, 0);

    // 2: positive clamp at beat 2 then recovery.
    run_op('{20, 20, -10, 0}, 0, 0, 0);
    check_last("t2", 21, 1);

    // 3: negative clamp.
    run_op('{-20, -20, -20, 5}, 0, 1, 0);
    check_last("t3", -27, 1);

    // 4: input gaps, output back-pressure, start pulsed in DONE.
    run_op('{3, 4, 5, 6}, 2, 3, 1);
    check_last("t4", 18, 0);
    chk("t4_idle_after", int'(busy), 0);

    // 5: reset mid-operation discards the partial sum.
    start_op(1'b0, 0);
    send_beat(9, 0, 0); send_beat(9, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_out_valid", int'(out_valid), 0);
    chk("t5_busy", int'(busy), 0);
    run_op('{1, 1, 1, 1}, 0, 0, 0);
    check_last("t5", 4, 0);

    // 6: beat presented in the start cycle is not taken.
    start_op(1'b1, 7);
    send_beat(1, 0, 0); send_beat(2, 0, 0); send_beat(3, 0, 0); send_beat(4, 0, 0);
    wait_out(0, 0);
    check_last("t6", 10, 0);

    // Randomized operations; the model checks every cycle.
    for (int op = 0; op < 60; op++) begin
      int idle_n;
      idle_n = $urandom_range(2);
      for (int k = 0; k < idle_n; k++) begin
        in_valid = 1'($urandom_range(1));
        in_data  = DATA_W'($urandom_range(63));
        tick();
      end
      start_op(1'($urandom_range(1)), int'($urandom_range(63)));
      if ($urandom_range(9) == 0) begin
        send_beat(int'($urandom_range(63)) - 32, $urandom_range(2), 1);
        send_beat(int'($urandom_range(63)) - 32, $urandom_range(2), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        for (int i = 0; i < NUM_TERMS; i++)
          send_beat(int'($urandom_range(63)) - 32, $urandom_range(2), 1);
        wait_out($urandom_range(3), 1'($urandom_range(1)));
      end
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
